// File: rtl/sym_stats_collector.sv
// sym_stats_collector
//   Running statistics over the per-word results of tt_um_symmetry_detector:
//   total word count, histogram of mismatch counts 0..4, and the current and
//   maximum run of consecutive symmetric words. All counters saturate at
//   all-ones; any attempt to increment past that sets the sticky 'sat' flag.
//
//   Optional feature macro: SYM_STATS_CHECK_EN
//     defined   : out-of-range mismatch (5..7) counts in total only and breaks
//                 the run; inconsistent sym/mismatch pairs set sticky 'err'.
//     undefined : no checking, 'err' tied 0, mismatch 5..7 clamps to bin 4.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   in_valid     a detector result is presented this cycle
//   in_sym       detector symmetric flag
//   in_mismatch  detector mismatched-pair count (legal 0..4)
//   clear        synchronous statistics clear (same effect as rst)
//   rd_sel       readback select: 0 total, 1..5 bin0..4, 6 cur_run, 7 max_run
//   rd_data      registered readback, 1-cycle latency from rd_sel
//   sat          sticky saturation flag
//   err          sticky input-consistency error flag
module sym_stats_collector #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sym,
  input  logic [2:0]       in_mismatch,
  input  logic             clear,
  input  logic [2:0]       rd_sel,
  output logic [CNT_W-1:0] rd_data,
  output logic             sat,
  output logic             err
);

  logic [CNT_W-1:0] total_q,   total_d;
  logic [CNT_W-1:0] bin_q [5];
  logic [CNT_W-1:0] bin_d [5];
  logic [CNT_W-1:0] cur_run_q, cur_run_d;
  logic [CNT_W-1:0] max_run_q, max_run_d;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;
  logic             sat_q,     sat_d;
`ifdef SYM_STATS_CHECK_EN
  logic             err_q,     err_d;
`endif

  logic       bin_en;
  logic [2:0] bin_idx;
  logic       run_en;

  always_comb begin
    total_d   = total_q;
    cur_run_d = cur_run_q;
    max_run_d = max_run_q;
    sat_d     = sat_q;
    for (int unsigned i = 0; i < 5; i++) bin_d[i] = bin_q[i];
`ifdef SYM_STATS_CHECK_EN
    err_d     = err_q;
    bin_en    = (in_mismatch <= 3'd4);
    bin_idx   = in_mismatch;
    run_en    = in_sym && (in_mismatch <= 3'd4);
`else
    bin_en    = 1'b1;
    bin_idx   = (in_mismatch > 3'd4) ? 3'd4 : in_mismatch;
    run_en    = in_sym;
`endif

    // Readback always samples pre-update counter values.
    case (rd_sel)
      3'd0:    rd_data_d = total_q;
      3'd1:    rd_data_d = bin_q[0];
      3'd2:    rd_data_d = bin_q[1];
      3'd3:    rd_data_d = bin_q[2];
      3'd4:    rd_data_d = bin_q[3];
      3'd5:    rd_data_d = bin_q[4];
      3'd6:    rd_data_d = cur_run_q;
      default: rd_data_d = max_run_q;
    endcase

    if (clear) begin
      total_d   = '0;
      cur_run_d = '0;
      max_run_d = '0;
      rd_data_d = '0;
      sat_d     = 1'b0;
      for (int unsigned i = 0; i < 5; i++) bin_d[i] = '0;
`ifdef SYM_STATS_CHECK_EN
      err_d     = 1'b0;
`endif
    end else if (in_valid) begin
      if (total_q == '1) sat_d = 1'b1;
      else               total_d = total_q + CNT_W'(1);

      for (int unsigned i = 0; i < 5; i++) begin
        if (bin_en && (bin_idx == 3'(i))) begin
          if (bin_q[i] == '1) sat_d = 1'b1;
          else                bin_d[i] = bin_q[i] + CNT_W'(1);
        end
      end

      if (run_en) begin
        if (cur_run_q == '1) sat_d = 1'b1;
        else                 cur_run_d = cur_run_q + CNT_W'(1);
        // Compare against the saturated next value in the same cycle.
        if (cur_run_d > max_run_q) max_run_d = cur_run_d;
      end else begin
        cur_run_d = '0;
      end

`ifdef SYM_STATS_CHECK_EN
      // Symmetric iff zero mismatches; anything else is inconsistent.
      if ((in_mismatch > 3'd4) || (in_sym != (in_mismatch == 3'd0)))
        err_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      total_q   <= '0;
      cur_run_q <= '0;
      max_run_q <= '0;
      rd_data_q <= '0;
      sat_q     <= 1'b0;
      for (int unsigned i = 0; i < 5; i++) bin_q[i] <= '0;
`ifdef SYM_STATS_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      total_q   <= total_d;
      cur_run_q <= cur_run_d;
      max_run_q <= max_run_d;
      rd_data_q <= rd_data_d;
      sat_q     <= sat_d;
      for (int unsigned i = 0; i < 5; i++) bin_q[i] <= bin_d[i];
`ifdef SYM_STATS_CHECK_EN
      err_q     <= err_d;
`endif
    end
  end

  assign rd_data = rd_data_q;
  assign sat     = sat_q;
`ifdef SYM_STATS_CHECK_EN
  assign err     = err_q;
`else
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_sym_stats_collector.sv
// Self-checking bench for sym_stats_collector. Two instances share stimulus:
// the default 16-bit build and a 4-bit build used to reach saturation.
module tb_sym_stats_collector;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_sym, clear;
  logic [2:0]  in_mismatch, rd_sel;
  logic [15:0] rd16;
  logic [3:0]  rd4;
  logic        sat16, err16, sat4, err4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sym_stats_collector u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sym(in_sym),
    .in_mismatch(in_mismatch), .clear(clear), .rd_sel(rd_sel),
    .rd_data(rd16), .sat(sat16), .err(err16)
  );

  sym_stats_collector #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sym(in_sym),
    .in_mismatch(in_mismatch), .clear(clear), .rd_sel(rd_sel),
    .rd_data(rd4), .sat(sat4), .err(err4)
  );

  // Reference model, index by readback select: 0 total, 1..5 bins, 6 cur, 7 max.
  // Model instance 0 is 16 bits wide, instance 1 is 4 bits wide.
  logic [15:0] m_cnt [2][8];
  bit          m_sat [2];
  bit          m_err [2];

  typedef struct {
    logic [15:0] rd0;
    logic [15:0] rd1;
  } exp_t;
  exp_t sb [$];

  function automatic logic [15:0] maxv(input int k);
    return (k == 0) ? 16'hFFFF : 16'h000F;
  endfunction

  task automatic m_inc(input int k, input int idx);
    if (m_cnt[k][idx] == maxv(k)) m_sat[k] = 1'b1;
    else m_cnt[k][idx] = m_cnt[k][idx] + 16'd1;
  endtask

  task automatic model_update(input bit v, input bit s, input bit [2:0] mm,
                              input bit c, input bit r);
    for (int k = 0; k < 2; k++) begin
      if (r || c) begin
        for (int j = 0; j < 8; j++) m_cnt[k][j] = 16'd0;
        m_sat[k] = 1'b0;
        m_err[k] = 1'b0;
      end else if (v) begin
        m_inc(k, 0);
`ifdef SYM_STATS_CHECK_EN
        if (mm > 3'd4) begin
          m_err[k] = 1'b1;
          m_cnt[k][6] = 16'd0;
        end else begin
          m_inc(k, 1 + int'(mm));
          if ((s && mm != 3'd0) || (!s && mm == 3'd0)) m_err[k] = 1'b1;
          if (s) begin
            m_inc(k, 6);
            if (m_cnt[k][6] > m_cnt[k][7]) m_cnt[k][7] = m_cnt[k][6];
          end else m_cnt[k][6] = 16'd0;
        end
`else
        m_inc(k, (mm > 3'd4) ? 5 : 1 + int'(mm));
        if (s) begin
          m_inc(k, 6);
          if (m_cnt[k][6] > m_cnt[k][7]) m_cnt[k][7] = m_cnt[k][6];
        end else m_cnt[k][6] = 16'd0;
`endif
      end
    end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, queue the readback expected at this edge, then
  // compare rd_data and the sticky flags just after the edge.
  task automatic step(input bit v, input bit s, input bit [2:0] mm,
                      input bit c, input bit r, input bit [2:0] sel);
    exp_t e;
    in_valid    = v;
    in_sym      = s;
    in_mismatch = mm;
    clear       = c;
    rst         = r;
    rd_sel      = sel;
    e.rd0 = (r || c) ? 16'd0 : m_cnt[0][sel];
    e.rd1 = (r || c) ? 16'd0 : m_cnt[1][sel];
    sb.push_back(e);
    @(posedge clk);
    model_update(v, s, mm, c, r);
    #1;
    e = sb.pop_front();
    check($sformatf("rd16_sel%0d", sel), rd16, e.rd0);
    check($sformatf("rd4_sel%0d", sel), {12'd0, rd4}, e.rd1);
    check("sat16", {15'd0, sat16}, {15'd0, m_sat[0]});
    check("sat4",  {15'd0, sat4},  {15'd0, m_sat[1]});
    check("err16", {15'd0, err16}, {15'd0, m_err[0]});
    check("err4",  {15'd0, err4},  {15'd0, m_err[1]});
  endtask

  task automatic read_all();
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'(i));
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 8; j++) m_cnt[k][j] = 16'd0;
      m_sat[k] = 1'b0;
      m_err[k] = 1'b0;
    end
    rst = 1'b1; in_valid = 1'b0; in_sym = 1'b0; in_mismatch = 3'd0;
    clear = 1'b0; rd_sel = 3'd0;

    // Reset state
    step(0, 0, 3'd0, 0, 1, 3'd0);
    step(0, 0, 3'd0, 0, 1, 3'd0);
    read_all();

    // Five samples; rd_sel=0 shows pre-update total each cycle
    step(1, 1, 3'd0, 0, 0, 3'd0);
    step(1, 0, 3'd1, 0, 0, 3'd0);
    step(1, 1, 3'd0, 0, 0, 3'd0);
    step(1, 1, 3'd0, 0, 0, 3'd7);
    step(1, 0, 3'd4, 0, 0, 3'd6);
    read_all();

    // Clear coincident with a valid sample drops the sample
    step(1, 1, 3'd0, 1, 0, 3'd0);
    read_all();

    // 16 symmetric words: 4-bit instance saturates on the 16th
    for (int i = 0; i < 16; i++) step(1, 1, 3'd0, 0, 0, 3'd7);
    read_all();

    // Out-of-range mismatch count
    step(0, 0, 3'd0, 1, 0, 3'd0);
    step(1, 0, 3'd6, 0, 0, 3'd0);
    read_all();

    // Inconsistent pair, then reset mid-stream
    step(0, 0, 3'd0, 1, 0, 3'd0);
    step(1, 1, 3'd2, 0, 0, 3'd0);
    read_all();
    step(0, 0, 3'd0, 0, 1, 3'd0);
    read_all();

    // First sample after reset starts from zero
    step(1, 1, 3'd0, 0, 0, 3'd0);
    read_all();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
